// File: rtl/elevator_pkg.sv
// elevator_pkg: car state type, one-hot floor codes (shared with the HEX display stage) and call-mask helpers
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} car_state_t;
  localparam logic [5:0] FLOOR_1  = 6'b000001;
  localparam logic [5:0] FLOOR_2  = 6'b000010;
  localparam logic [5:0] FLOOR_2M = 6'b000100;
  localparam logic [5:0] FLOOR_3  = 6'b001000;
  localparam logic [5:0] FLOOR_3M = 6'b010000;
  localparam logic [5:0] FLOOR_4  = 6'b100000;
  function automatic logic [5:0] below_mask(input logic [5:0] f);
    return f - 6'd1;
  endfunction
  function automatic logic [5:0] above_mask(input logic [5:0] f);
    return ~(f | below_mask(f));
  endfunction
endpackage

// File: rtl/elevator_ctrl_call_latch.sv
// call_latch: pending-call register; in clk, reset_n, call_req[6], clr[6], hold_floor[6]; out pending[6] (clear wins, hold_floor bits not latched)
module call_latch
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] call_req,
  input  logic [5:0] clr,
  input  logic [5:0] hold_floor,
  output logic [5:0] pending
);
  logic [5:0] pending_q, pending_d;
  assign pending_d = (pending_q | (call_req & ~hold_floor)) & ~clr;
  assign pending = pending_q;
  always_ff @(posedge clk) begin
    if (!reset_n) pending_q <= '0;
    else pending_q <= pending_d;
  end
endmodule

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: SCAN car FSM with shared travel/dwell timer; in clk, reset_n, call_req[6]; out currentFloor[6], Up, Down, door_open, pending[6]
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] call_req,
  output logic [5:0] currentFloor,
  output logic       Up,
  output logic       Down,
  output logic       door_open,
  output logic [5:0] pending
);
  localparam int TW = $clog2(TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] D_LAST = TW'(DOOR_CYCLES - 1);
  car_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0] floor_q, floor_d, nxt, clr, hold;
  logic dir_q, dir_d, up_q, down_q, door_q, go_up, go_dn, more;
  call_latch u_latch (
    .clk       (clk),
    .reset_n   (reset_n),
    .call_req  (call_req),
    .clr       (clr),
    .hold_floor(hold),
    .pending   (pending)
  );
  assign hold  = state_q == DOOR_OPEN ? floor_q : '0;
  assign go_up = |(pending & above_mask(floor_q));
  assign go_dn = |(pending & below_mask(floor_q));
  assign nxt   = state_q == MOVE_UP ? floor_q << 1 : floor_q >> 1;
  assign more  = |(pending & (state_q == MOVE_UP ? above_mask(nxt) : below_mask(nxt)));
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    floor_d = floor_q;
    dir_d   = dir_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (|(pending & floor_q)) begin
          state_d = DOOR_OPEN;
          clr     = floor_q;
        end else if (go_up && (dir_q || !go_dn)) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
        end else if (go_dn) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer_q == T_LAST) begin
          timer_d = '0;
          floor_d = nxt;
          if (|(pending & nxt)) begin
            state_d = DOOR_OPEN;
            clr     = nxt;
          end else if (!more) begin
            state_d = IDLE;
          end
        end
      end
      DOOR_OPEN: begin
        if (|(call_req & floor_q)) begin
          timer_d = '0;
        end else if (timer_q == D_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      floor_q <= FLOOR_1;
      dir_q   <= 1'b1;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      up_q    <= state_d == MOVE_UP;
      down_q  <= state_d == MOVE_DOWN;
      door_q  <= state_d == DOOR_OPEN;
    end
  end
  assign currentFloor = floor_q;
  assign Up           = up_q;
  assign Down         = down_q;
  assign door_open    = door_q;
  a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot(floor_q));
  a_top:    assert property (@(posedge clk) disable iff (!reset_n) !(state_q == MOVE_UP && floor_q == FLOOR_4));
  a_bot:    assert property (@(posedge clk) disable iff (!reset_n) !(state_q == MOVE_DOWN && floor_q == FLOOR_1));
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed plus random calls checked each cycle against a floor-index reference model
module tb_elevator_ctrl;
  localparam int TR = 4;
  localparam int DR = 3;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] call_req = '0;
  logic [5:0] currentFloor, pending;
  logic Up, Down, door_open;
  int total = 0;
  int bad = 0;
  int m_pos, m_mode, m_left;
  bit m_dir;
  logic [5:0] m_pend;
  bit seen_dn;
  elevator_ctrl #(.TRAVEL_CYCLES(TR), .DOOR_CYCLES(DR)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .call_req    (call_req),
    .currentFloor(currentFloor),
    .Up          (Up),
    .Down        (Down),
    .door_open   (door_open),
    .pending     (pending)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit calls_beyond(input bit up, input int p);
    for (int i = 0; i < 6; i++)
      if (m_pend[i] && (up ? i > p : i < p)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_edge(input logic rn, input logic [5:0] req);
    logic [5:0] set, clr;
    bit a, b;
    set = req;
    clr = '0;
    if (!rn) begin
      m_pos = 0; m_mode = 0; m_left = 0; m_dir = 1'b1; m_pend = '0;
      return;
    end
    if (m_mode == 3 && req[m_pos]) set[m_pos] = 1'b0;
    a = calls_beyond(1'b1, m_pos);
    b = calls_beyond(1'b0, m_pos);
    case (m_mode)
      0: begin
        if (m_pend[m_pos]) begin
          m_mode = 3; m_left = DR; clr[m_pos] = 1'b1;
        end else if (a && (m_dir || !b)) begin
          m_mode = 1; m_dir = 1'b1; m_left = TR;
        end else if (b) begin
          m_mode = 2; m_dir = 1'b0; m_left = TR;
        end
      end
      1, 2: begin
        m_left--;
        if (m_left == 0) begin
          m_pos += (m_mode == 1) ? 1 : -1;
          if (m_pend[m_pos]) begin
            m_mode = 3; m_left = DR; clr[m_pos] = 1'b1;
          end else if (calls_beyond(m_mode == 1, m_pos)) m_left = TR;
          else m_mode = 0;
        end
      end
      default: begin
        if (req[m_pos]) m_left = DR;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
    endcase
    m_pend = (m_pend | set) & ~clr;
  endtask
  task automatic tick(input logic rn, input logic [5:0] req);
    reset_n = rn;
    call_req = req;
    @(posedge clk);
    model_edge(rn, req);
    #1;
    chk("floor", currentFloor, 6'(1 << m_pos));
    chk("up", 6'(Up), 6'(m_mode == 1));
    chk("down", 6'(Down), 6'(m_mode == 2));
    chk("door", 6'(door_open), 6'(m_mode == 3));
    chk("pending", pending, m_pend);
  endtask
  initial begin
    tick(1'b0, '0);
    tick(1'b0, '0);
    for (int i = 0; i < 20; i++) tick(1'b1, '0);
    chk("idle_floor", currentFloor, 6'b000001);
    tick(1'b1, 6'b100000);
    tick(1'b1, '0);
    chk("up_2cyc", 6'(Up), 6'd1);
    for (int i = 0; i < 60 && !door_open; i++) tick(1'b1, '0);
    chk("top_floor", currentFloor, 6'b100000);
    chk("top_up_off", 6'(Up), 6'd0);
    chk("top_pend", pending, 6'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, '0);
    chk("top_door_done", 6'(door_open), 6'd0);
    tick(1'b0, '0);
    tick(1'b1, 6'b100000);
    for (int i = 0; i < 60 && currentFloor != 6'b001000; i++) tick(1'b1, '0);
    chk("mid_up", 6'(Up), 6'd1);
    tick(1'b0, '0);
    chk("rst_floor", currentFloor, 6'b000001);
    chk("rst_up", 6'(Up), 6'd0);
    chk("rst_pend", pending, 6'd0);
    tick(1'b1, 6'b100000);
    for (int i = 0; i < 60 && currentFloor != 6'b001000; i++) tick(1'b1, '0);
    tick(1'b1, 6'b100100);
    for (int i = 0; i < 60 && !door_open; i++) tick(1'b1, '0);
    chk("sweep_first", currentFloor, 6'b100000);
    for (int i = 0; i < 60 && door_open; i++) tick(1'b1, '0);
    seen_dn = 1'b0;
    for (int i = 0; i < 60 && !door_open; i++) begin
      tick(1'b1, '0);
      seen_dn |= Down;
    end
    chk("rev_down", 6'(seen_dn), 6'd1);
    chk("stop_2m", currentFloor, 6'b000100);
    for (int i = 0; i < 60 && door_open; i++) tick(1'b1, '0);
    tick(1'b1, 6'b000100);
    tick(1'b1, 6'b000100);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 6'b000100);
      chk("door_held", 6'(door_open), 6'd1);
    end
    tick(1'b1, '0);
    chk("rel_1", 6'(door_open), 6'd1);
    tick(1'b1, '0);
    chk("rel_2", 6'(door_open), 6'd1);
    tick(1'b1, '0);
    chk("rel_3", 6'(door_open), 6'd0);
    chk("rel_pend", pending, 6'd0);
    tick(1'b1, 6'b001000);
    for (int i = 0; i < 40 && !(m_mode == 1 && m_left == 1); i++) tick(1'b1, '0);
    tick(1'b1, 6'b001000);
    chk("arr_door", 6'(door_open), 6'd1);
    chk("arr_pend", pending, 6'd0);
    for (int i = 0; i < 3; i++) tick(1'b1, '0);
    for (int i = 0; i < 6; i++) begin
      chk("one_door", 6'(door_open), 6'd0);
      tick(1'b1, '0);
    end
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 399) != 0, $urandom_range(0, 5) == 0 ? 6'($urandom) : 6'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
